cla_nibble_sequencer: RTL and testbench
=======================================

CLA_NIBBLE_SEQUENCER -- requirements
Module: cla_nibble_sequencer

Interface
REQ-001: Parameter WIDTH, default 16, operand width in bits; SHALL be a multiple of 4 and at least 8.
REQ-002: Derived constant N = WIDTH/4 is the nibble count; the index register SHALL be wide enough for N-1.
REQ-003: Port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-004: Port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005: Port in_valid, input, 1, the requester presents an operation.
REQ-006: Port in_ready, output, 1, the block can accept an operation.
REQ-007: Port a, input, WIDTH, operand A.
REQ-008: Port b, input, WIDTH, operand B.
REQ-009: Port cin, input, 1, carry-in.
REQ-010: Port out_valid, output, 1, the result is available.
REQ-011: Port out_ready, input, 1, the consumer takes the result.
REQ-012: Port s, output, WIDTH, the sum A+B+cin modulo 2^WIDTH.
REQ-013: Port cout, output, 1, carry out of the MSB.
REQ-014: Port ovf, output, 1, two's-complement overflow, defined as the carry into the MSB XOR cout.

Function
REQ-015: A single instance of the team's 4-bit carry_look_ahead_adder SHALL be time-shared over all nibbles; no other adder is permitted in the datapath.
REQ-016: The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-017: in_ready SHALL equal 1 only in IDLE.
REQ-018: out_valid SHALL equal 1 only in DONE.
REQ-019: IDLE with in_valid=1 SHALL, at the clock edge, do all of the following:
- register a, b and cin;
- clear the nibble index to 0 and clear s;
- load the carry register with cin;
- go to BUSY.
REQ-020: in_valid in BUSY or DONE SHALL be ignored; operands are not re-sampled.
REQ-021: In BUSY, each cycle the adder SHALL take nibble[idx] of A, nibble[idx] of B and the carry register; at the edge:
- the sum nibble is written to s[4*idx+3:4*idx];
- the carry register takes the adder cout;
- idx increments.
REQ-022: At the edge where idx = N-1, the block SHALL also:
- latch cout from the adder;
- latch ovf = (A[W-1]^B[W-1]^sum_MSB) XOR adder cout, where sum_MSB is the MSB of the sum nibble just produced;
- go to DONE.
REQ-023: Latency: out_valid SHALL rise exactly N clock edges after the accepting edge (4 edges for WIDTH=16).
REQ-024: In DONE, s, cout and ovf SHALL stay stable until the handshake completes; out_ready=0 SHALL hold DONE indefinitely.
REQ-025: DONE with out_ready=1 SHALL go to IDLE at the edge; a new operation SHALL NOT be accepted in that same cycle.
REQ-026: s, cout and ovf SHALL retain the last result while in IDLE until the next accept clears s.
REQ-027: Throughput SHALL be one operation per N+2 cycles when in_valid and out_ready are held at 1.
REQ-028: Arithmetic SHALL be unsigned modulo 2^WIDTH; cout and ovf are reported independently, with no saturation.
REQ-029: No combinational path SHALL exist from in_valid or out_ready to any output.

Reset
REQ-030: rst_n=0 SHALL immediately, without waiting for clk, force all of the following:
- state IDLE and idx 0;
- the carry register, s, cout and ovf to 0;
- out_valid to 0 and in_ready to 1.
REQ-031: Reset asserted in BUSY or DONE SHALL discard the operation in flight; no partial result may appear after reset.
REQ-032: After rst_n rises, the first clk edge with in_valid=1 SHALL accept normally.

Verification
REQ-033: WIDTH=16, a=0x0001, b=0x0001, cin=0 -> s=0x0002, cout=0, ovf=0, with out_valid high 4 edges after the accepting edge.
REQ-034: a=0xFFFF, b=0x0001, cin=0 -> s=0x0000, cout=1, ovf=0, with the carry rippling through all 4 nibbles.
REQ-035: a=0x7FFF, b=0x0001, cin=0 -> s=0x8000, cout=0, ovf=1; and a=0x00FF, b=0x0F01, cin=1 -> s=0x1001, cout=0.
REQ-036: Backpressure: out_ready=0 for 10 cycles in DONE -> s, cout and ovf are unchanged and in_ready stays 0 throughout; then out_ready=1 -> IDLE next edge.
REQ-037: in_valid pulsed with a different a/b during BUSY -> the result matches the originally accepted operands.
REQ-038: rst_n=0 asserted mid-BUSY (idx=2) -> all outputs 0 and in_ready=1 asynchronously; the next accept of a=0x1234, b=0x1111 gives s=0x2345.

Source files
------------

// File: rtl/cla_nibble_sequencer.sv
// Multi-cycle adder: one 4-bit carry look-ahead cell iterated over N nibbles.
// Ports: clk, rst_n (async low), in_valid/in_ready, a, b, cin,
//        out_valid/out_ready, s, cout, ovf.

module carry_look_ahead_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        sum  = p ^ c[3:0];
        cout = c[4];
    end
endmodule

module cla_nibble_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);
    localparam int N  = WIDTH / 4;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [IW+1:0]    lo;
    logic [3:0]       nib_a;
    logic [3:0]       nib_b;
    logic [3:0]       nib_s;
    logic             nib_c;

    assign lo    = {idx_q, 2'b00};
    assign nib_a = a_q[lo +: 4];
    assign nib_b = b_q[lo +: 4];

    carry_look_ahead_adder u_cla (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_q),
        .sum  (nib_s),
        .cout (nib_c)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        s_d         = s_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d        = a;
                    b_d        = b;
                    carry_d    = cin;
                    idx_d      = '0;
                    s_d        = '0;
                    in_ready_d = 1'b0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                s_d[lo +: 4] = nib_s;
                carry_d      = nib_c;
                idx_d        = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    // Carry into the MSB is recovered from the MSB sum bit.
                    cout_d      = nib_c;
                    ovf_d       = (a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ nib_s[3])
                                ^ nib_c;
                    idx_d       = '0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            s_q         <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            s_q         <= s_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign s         = s_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Directed testbench for cla_nibble_sequencer (WIDTH=16).
// One task per scenario; expected values computed by hand.

module tb_cla_nibble_sequencer;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] s;
    logic        cout;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    cla_nibble_sequencer #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one operation and wait for out_valid; lat = edges after accept.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb,
                          input logic tc, output int lat);
        int k;
        k = 0;
        while (!in_ready && k < 20) begin
            step();
            k++;
        end
        a        = ta;
        b        = tb;
        cin      = tc;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        step();
        step();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || s !== 16'h0 ||
            cout !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset: rdy=%b vld=%b s=%h c=%b o=%b want 1 0 0000 0 0",
                     in_ready, out_valid, s, cout, ovf);
        end
        #2 rst_n = 1'b1;
        step();
    endtask

    task automatic test_add();
        logic [15:0] va [5];
        logic [15:0] vb [5];
        logic        vc [5];
        logic [15:0] es [5];
        logic        ec [5];
        logic        eo [5];
        int lat;
        va = '{16'h0001, 16'hFFFF, 16'h7FFF, 16'h00FF, 16'h8000};
        vb = '{16'h0001, 16'h0001, 16'h0001, 16'h0F01, 16'h8000};
        vc = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        es = '{16'h0002, 16'h0000, 16'h8000, 16'h1001, 16'h0000};
        ec = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        eo = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            run_op(va[i], vb[i], vc[i], lat);
            checks++;
            if (lat !== 4) begin
                errors++;
                $display("FAIL latency[%0d]: got %0d want 4", i, lat);
            end
            checks++;
            if (s !== es[i] || cout !== ec[i] || ovf !== eo[i]) begin
                errors++;
                $display("FAIL add[%0d]: s=%h c=%b o=%b want s=%h c=%b o=%b",
                         i, s, cout, ovf, es[i], ec[i], eo[i]);
            end
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL release[%0d]: vld=%b rdy=%b want 0 1",
                         i, out_valid, in_ready);
            end
            checks++;
            if (s !== es[i] || cout !== ec[i] || ovf !== eo[i]) begin
                errors++;
                $display("FAIL idle_hold[%0d]: s=%h c=%b o=%b want %h %b %b",
                         i, s, cout, ovf, es[i], ec[i], eo[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        run_op(16'h7FFF, 16'h0001, 1'b0, lat);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            a        = 16'h1111;
            b        = 16'h2222;
            step();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || s !== 16'h8000 ||
                cout !== 1'b0 || ovf !== 1'b1) begin
                errors++;
                $display("FAIL backpressure[%0d]: vld=%b rdy=%b s=%h c=%b o=%b want 1 0 8000 0 1",
                         i, out_valid, in_ready, s, cout, ovf);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: vld=%b rdy=%b want 0 1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_busy_ignore();
        int k;
        a        = 16'h1111;
        b        = 16'h2222;
        cin      = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        a        = 16'hFFFF;
        b        = 16'hFFFF;
        cin      = 1'b1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 20) begin
            step();
            k++;
        end
        checks++;
        if (out_valid !== 1'b1 || s !== 16'h3333 || cout !== 1'b0 ||
            ovf !== 1'b0) begin
            errors++;
            $display("FAIL busy_ignore: vld=%b s=%h c=%b o=%b want 1 3333 0 0",
                     out_valid, s, cout, ovf);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int first;
        int second;
        int bad;
        first  = -1;
        second = -1;
        bad    = 0;
        a         = 16'h0F0F;
        b         = 16'h0101;
        cin       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            if (out_valid) begin
                if (s !== 16'h1011 || cout !== 1'b0 || ovf !== 1'b0) bad++;
                if (first < 0) first = c;
                else if (second < 0) second = c;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (first < 0 || second < 0 || (second - first) !== 6) begin
            errors++;
            $display("FAIL throughput: first=%0d second=%0d want spacing 6",
                     first, second);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL b2b_result: %0d bad results want 0 (s=%h)", bad, s);
        end
        for (int c = 0; c < 8; c++) step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_busy();
        int lat;
        a        = 16'h1234;
        b        = 16'h1111;
        cin      = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || s !== 16'h0 ||
            cout !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: rdy=%b vld=%b s=%h c=%b o=%b want 1 0 0000 0 0",
                     in_ready, out_valid, s, cout, ovf);
        end
        step();
        step();
        #2 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) step();
        checks++;
        if (out_valid !== 1'b0 || s !== 16'h0) begin
            errors++;
            $display("FAIL no_partial: vld=%b s=%h want 0 0000", out_valid, s);
        end
        run_op(16'h1234, 16'h1111, 1'b0, lat);
        checks++;
        if (lat !== 4 || s !== 16'h2345 || cout !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: lat=%0d s=%h c=%b o=%b want 4 2345 0 0",
                     lat, s, cout, ovf);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_backpressure();
        test_busy_ignore();
        test_back_to_back();
        test_reset_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
